axis_fifo_sync_pkt: RTL and testbench

//  Single-clock AXI4-Stream FIFO. Carries tid/tdest/tlast/tdata per beat and generalises
//  the basic AXIS FIFO wrappers with a store-and-forward packet mode and an occupancy output.

---
 rtl/axis_fifo_sync_pkt.sv | 146 ++++++++++++++
 tb/tb_axis_fifo_sync_pkt.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_sync_pkt.sv
`default_nettype none
// ============================================================================
// axis_fifo_sync_pkt : single-clock AXI4-Stream FWFT FIFO with optional
// store-and-forward packet mode, forced cut-through and occupancy output.
// Revision: 1.0
// ============================================================================
module axis_fifo_sync_pkt #(
  parameter int    TDataWidth = 32,
  parameter int    TidWidth   = 8,
  parameter int    TdestWidth = 8,
  parameter int    FifoDepth  = 16,
  parameter string PacketMode = "no"
) (
  input  logic                          aclk,
  input  logic                          arstn,
  input  logic [TidWidth-1:0]           s_axis_tid,
  input  logic [TdestWidth-1:0]         s_axis_tdest,
  input  logic [TDataWidth-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [TidWidth-1:0]           m_axis_tid,
  output logic [TdestWidth-1:0]         m_axis_tdest,
  output logic [TDataWidth-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FifoDepth):0]    occupancy,
  output logic                          oversize
);

  localparam int AddressWidth = $clog2(FifoDepth);
  localparam int PtrWidth     = AddressWidth + 1;
  localparam int BeatWidth    = TidWidth + TdestWidth + TDataWidth + 1;
  localparam bit IsPacket     = (PacketMode == "yes");
  localparam logic [PtrWidth-1:0] DepthVal = PtrWidth'(FifoDepth);

  typedef enum logic [0:0] {
    ST_STORE = 1'b0,
    ST_CUT   = 1'b1
  } state_e;

  logic [BeatWidth-1:0] mem_q [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0]  count_q, count_d;
  logic [PtrWidth-1:0]  pkt_cnt_q, pkt_cnt_d;
  state_e               state_q, state_d;
  logic                 tready_q;
  logic                 m_valid_q, m_valid_d;
  logic [BeatWidth-1:0] m_beat_q, m_beat_d;
  logic [BeatWidth-1:0] wr_beat;
  logic                 wr_en, rd_en, wr_last, rd_last, empty_d;

  assign wr_beat = {s_axis_tid, s_axis_tdest, s_axis_tdata, s_axis_tlast};
  assign wr_en   = s_axis_tvalid & tready_q;
  assign rd_en   = m_valid_q & m_axis_tready;
  assign wr_last = wr_en & s_axis_tlast;
  assign rd_last = rd_en & m_beat_q[0];

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PtrWidth'(wr_en);
    rd_ptr_d  = rd_ptr_q + PtrWidth'(rd_en);
    empty_d   = (wr_ptr_d == rd_ptr_d);

    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + PtrWidth'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - PtrWidth'(1);
    end

    pkt_cnt_d = pkt_cnt_q;
    if (wr_last && !rd_last) begin
      pkt_cnt_d = pkt_cnt_q + PtrWidth'(1);
    end else if (!wr_last && rd_last) begin
      pkt_cnt_d = pkt_cnt_q - PtrWidth'(1);
    end

    // Next head beat; bypass the write when it lands in the slot being exposed.
    m_beat_d = mem_q[rd_ptr_d[AddressWidth-1:0]];
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      m_beat_d = wr_beat;
    end

    m_valid_d = !empty_d &&
                (!IsPacket || (pkt_cnt_d != '0) || (state_d == ST_CUT));
  end

  // Cut-through is entered when the FIFO is full of an incomplete packet.
  always_comb begin
    state_d = state_q;
    if (IsPacket) begin
      case (state_q)
        ST_STORE: if ((count_d == DepthVal) && (pkt_cnt_d == '0)) state_d = ST_CUT;
        ST_CUT:   if (rd_last) state_d = ST_STORE;
        default:  state_d = ST_STORE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_STORE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
      tready_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_beat_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_cnt_q <= pkt_cnt_d;
      tready_q  <= (count_d != DepthVal);
      m_valid_q <= m_valid_d;
      m_beat_q  <= m_beat_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AddressWidth-1:0]] <= wr_beat;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_beat_q[0];
  assign m_axis_tdata  = m_beat_q[TDataWidth:1];
  assign m_axis_tdest  = m_beat_q[TDataWidth+TdestWidth:TDataWidth+1];
  assign m_axis_tid    = m_beat_q[BeatWidth-1 -: TidWidth];
  assign occupancy     = count_q;
  assign oversize      = (state_q == ST_CUT);

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_sync_pkt.sv
`default_nettype none
// ============================================================================
// tb_axis_fifo_sync_pkt : scoreboard bench for a plain depth-16 instance and a
// packet-mode depth-8 instance. Revision: 1.0
// ============================================================================
module tb_axis_fifo_sync_pkt;

  typedef struct packed {
    logic [7:0]  tid;
    logic [7:0]  tdest;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic aclk  = 1'b0;
  logic arstn = 1'b0;
  always #5 aclk = ~aclk;

  logic [7:0]  s_tid [2];
  logic [7:0]  s_tdest [2];
  logic [31:0] s_tdata [2];
  logic        s_tlast [2];
  logic        s_tvalid [2];
  logic        s_tready [2];
  logic [7:0]  m_tid [2];
  logic [7:0]  m_tdest [2];
  logic [31:0] m_tdata [2];
  logic        m_tlast [2];
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic        ovs [2];
  logic [4:0]  occ0;
  logic [3:0]  occ1;
  logic        live;
  int          n_tests = 0;
  int          n_fail  = 0;

  axis_fifo_sync_pkt #(
    .TDataWidth(32), .TidWidth(8), .TdestWidth(8), .FifoDepth(16), .PacketMode("no")
  ) u_plain (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tid(s_tid[0]), .s_axis_tdest(s_tdest[0]), .s_axis_tdata(s_tdata[0]),
    .s_axis_tlast(s_tlast[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tid(m_tid[0]), .m_axis_tdest(m_tdest[0]), .m_axis_tdata(m_tdata[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .occupancy(occ0), .oversize(ovs[0])
  );

  axis_fifo_sync_pkt #(
    .TDataWidth(32), .TidWidth(8), .TdestWidth(8), .FifoDepth(8), .PacketMode("yes")
  ) u_pkt (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tid(s_tid[1]), .s_axis_tdest(s_tdest[1]), .s_axis_tdata(s_tdata[1]),
    .s_axis_tlast(s_tlast[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tid(m_tid[1]), .m_axis_tdest(m_tdest[1]), .m_axis_tdata(m_tdata[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .occupancy(occ1), .oversize(ovs[1])
  );

  task automatic check(input string nm, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d actual=%0h expected=%0h t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  always @(posedge aclk or negedge arstn) begin
    if (!arstn) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Monitors: a queue of accepted beats per instance plus the packet-mode
  // release rules (complete packet stored, or forced cut-through when full).
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int DEP = (g == 0) ? 16 : 8;
    localparam bit PKT = (g == 1);
    beat_t q[$];
    int    qsz = 0;
    bit    cut = 1'b0;

    always @(negedge aclk) begin
      beat_t      b, e;
      int         npk;
      bit         pl;
      logic [4:0] occ;
      occ = (g == 0) ? occ0 : {1'b0, occ1};
      if (!arstn) begin
        q.delete();
        cut = 1'b0;
        check("rst_tvalid", g, m_tvalid[g], 0);
        check("rst_occupancy", g, occ, 0);
        check("rst_oversize", g, ovs[g], 0);
        check("rst_s_tready", g, s_tready[g], 0);
      end else begin
        npk = 0;
        foreach (q[k]) if (q[k].last) npk++;
        check("occupancy", g, occ, q.size());
        if (live) check("s_tready", g, s_tready[g], q.size() != DEP);
        check("m_tvalid", g, m_tvalid[g], (q.size() > 0) && (!PKT || npk > 0 || cut));
        check("oversize", g, ovs[g], cut);
        pl = 1'b0;
        if (m_tvalid[g] && m_tready[g]) begin
          check("sb_nonempty", g, q.size() != 0, 1);
          if (q.size() != 0) begin
            e  = q.pop_front();
            b  = '{tid: m_tid[g], tdest: m_tdest[g], data: m_tdata[g], last: m_tlast[g]};
            check("beat", g, b, e);
            pl = e.last;
          end
        end
        if (s_tvalid[g] && s_tready[g]) begin
          q.push_back('{tid: s_tid[g], tdest: s_tdest[g], data: s_tdata[g], last: s_tlast[g]});
        end
        if (PKT) begin
          npk = 0;
          foreach (q[k]) if (q[k].last) npk++;
          if (cut && pl) cut = 1'b0;
          else if (!cut && q.size() == DEP && npk == 0) cut = 1'b1;
        end
      end
      qsz = q.size();
    end
  end

  task automatic send(input int i, input logic [31:0] d, input logic l);
    int n;
    s_tvalid[i] = 1'b1;
    s_tdata[i]  = d;
    s_tlast[i]  = l;
    s_tid[i]    = 8'($urandom);
    s_tdest[i]  = 8'($urandom);
    n = 0;
    @(negedge aclk);
    while (!s_tready[i] && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 300) check("send_timeout", i, n, 0);
    @(posedge aclk);
    #1;
    s_tvalid[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i);
    int n;
    n = 0;
    @(negedge aclk);
    while (((i == 0) ? g_mon[0].qsz : g_mon[1].qsz) != 0 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    check("drain", i, (i == 0) ? g_mon[0].qsz : g_mon[1].qsz, 0);
    @(posedge aclk);
    #1;
  endtask

  task automatic src(input int i, input int nb);
    int left;
    left = 0;
    for (int n = 0; n < nb; n++) begin
      if (left == 0) left = (i == 1) ? int'($urandom_range(12, 1)) : int'($urandom_range(4, 1));
      left--;
      send(i, $urandom, (left == 0) || (n == nb - 1));
      if ($urandom_range(3) == 0) begin
        @(posedge aclk);
        #1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit stop;
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tdata[i] = '0;
      s_tid[i] = '0; s_tdest[i] = '0; m_tready[i] = 1'b0;
    end
    repeat (3) @(posedge aclk);
    #1 arstn = 1'b1;

    // Plain FWFT: three beats streamed straight through.
    m_tready[0] = 1'b1;
    for (int n = 0; n < 3; n++) send(0, 32'hA0 + n, n == 2);
    wait_drain(0);

    // Plain fill to full, then a single read must reopen the input.
    m_tready[0] = 1'b0;
    for (int n = 0; n < 16; n++) send(0, 32'hB0 + n, 1'b0);
    @(negedge aclk);
    check("full_occupancy", 0, occ0, 16);
    check("full_tready", 0, s_tready[0], 0);
    @(posedge aclk); #1 m_tready[0] = 1'b1;
    @(posedge aclk); #1 m_tready[0] = 1'b0;
    @(negedge aclk);
    check("tready_after_read", 0, s_tready[0], 1);
    @(posedge aclk); #1;
    send(0, 32'hC0, 1'b1);
    m_tready[0] = 1'b1;
    wait_drain(0);

    // Packet mode: 4-beat packet held until its tlast is stored.
    m_tready[1] = 1'b1;
    for (int n = 0; n < 4; n++) send(1, 32'h300 + n, n == 3);
    wait_drain(1);

    // Oversize packet forces cut-through.
    for (int n = 0; n < 12; n++) send(1, 32'h400 + n, n == 11);
    wait_drain(1);
    check("oversize_cleared", 1, ovs[1], 0);

    // Simultaneous tlast read and tlast write keeps the next packet valid.
    m_tready[1] = 1'b0;
    send(1, 32'h50, 1'b1);
    send(1, 32'h51, 1'b0);
    m_tready[1] = 1'b1;
    send(1, 32'h52, 1'b1);
    @(negedge aclk);
    check("no_gap_tvalid", 1, m_tvalid[1], 1);
    wait_drain(1);

    // Randomly throttled traffic on both instances.
    stop = 1'b0;
    fork
      begin
        fork
          src(0, 500);
          src(1, 500);
        join
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge aclk);
          #1;
          m_tready[0] = ($urandom_range(3) != 0);
          m_tready[1] = ($urandom_range(3) != 0);
        end
      end
    join
    m_tready[0] = 1'b1;
    m_tready[1] = 1'b1;
    wait_drain(0);
    wait_drain(1);

    // Asynchronous reset with beats stored mid-packet.
    m_tready[0] = 1'b0;
    m_tready[1] = 1'b0;
    for (int n = 0; n < 5; n++) send(0, 32'h600 + n, 1'b0);
    for (int n = 0; n < 8; n++) send(1, 32'h700 + n, 1'b0);
    @(negedge aclk);
    check("pre_rst_tvalid", 0, m_tvalid[0], 1);
    check("pre_rst_oversize", 1, ovs[1], 1);
    @(posedge aclk);
    #3 arstn = 1'b0;
    #1;
    check("async_tvalid", 0, m_tvalid[0], 0);
    check("async_occupancy", 0, occ0, 0);
    check("async_oversize", 1, ovs[1], 0);
    check("async_occupancy", 1, occ1, 0);
    repeat (2) @(posedge aclk);
    #1 arstn = 1'b1;
    m_tready[0] = 1'b1;
    m_tready[1] = 1'b1;
    send(0, 32'h800, 1'b1);
    send(1, 32'h900, 1'b1);
    wait_drain(0);
    wait_drain(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
